// File: rtl/regfile32.sv
// 32 x W MIPS register file: two combinational read ports, one clocked write port, and a committed-write counter.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module regfile32 #(
  parameter int N_REGS = 32,
  parameter int W      = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we3,
  input  logic [4:0]       a3,
  input  logic [W-1:0]     wd3,
  input  logic [4:0]       a1,
  input  logic [4:0]       a2,
  output logic [W-1:0]     rd1,
  output logic [W-1:0]     rd2,
  output logic [CNT_W-1:0] wr_count
);

  // $0 has no storage; reads of address 0 are forced to zero below.
  logic [W-1:0]     regs [1:N_REGS-1];
  logic [CNT_W-1:0] cnt;
  logic             commit;

  assign commit   = we3 && (a3 != 5'd0);
  assign wr_count = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
      cnt <= '0;
    end else if (commit) begin
      regs[a3] <= wd3;
      cnt      <= cnt + 1'b1;
    end
  end

  always_comb begin
    rd1 = (a1 == 5'd0) ? '0 : regs[a1];
    rd2 = (a2 == 5'd0) ? '0 : regs[a2];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so a same-cycle reader sees it before the edge.
    if (!rst) begin
      rd1 = '0;
      rd2 = '0;
    end else begin
      if (commit && (a3 == a1)) rd1 = wd3;
      if (commit && (a3 == a2)) rd2 = wd3;
    end
`endif
  end

endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: directed steps plus randomized traffic against an array-based reference model.
module tb_regfile32;
  logic        clk = 1'b0;
  logic        rst;
  logic        we3;
  logic [4:0]  a3, a1, a2;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and write tally.
  logic [31:0] m_regs [32];
  int          m_cnt;

  regfile32 #(.N_REGS(32), .W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, applying the architectural rules to the model.
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else if (we3 && a3 != 5'd0) begin
      m_regs[a3] = wd3;
      m_cnt = (m_cnt + 1) % 65536;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst) v = 32'h0;
    else if (we3 && a3 != 5'd0 && a3 == a) v = wd3;
`endif
    return v;
  endfunction

  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    we3 = 1'b1; a3 = addr; wd3 = data;
    cycle();
    we3 = 1'b0;
  endtask

  logic [31:0] exp9;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;

    // Reset held for two edges with a competing write.
    rst = 1'b0; we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a1 = 5'd0; a2 = 5'd0;
    #2;
    check("pre_reset_r0", rd1, 32'h0);
    cycle();
    cycle();
    rst = 1'b1; we3 = 1'b0; a1 = 5'd5; a2 = 5'd17;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_cnt", {16'h0, wr_count}, 32'h0);

    // Basic write/read.
    write(5'd8, 32'h12345678);
    write(5'd31, 32'hCAFEF00D);
    a1 = 5'd8; a2 = 5'd31;
    #1;
    check("basic_rd1", rd1, 32'h12345678);
    check("basic_rd2", rd2, 32'hCAFEF00D);
    check("basic_cnt", {16'h0, wr_count}, 32'd2);

    // $0 protection.
    write(5'd0, 32'hFFFFFFFF);
    a1 = 5'd0;
    #1;
    check("r0_read", rd1, 32'h0);
    check("r0_cnt", {16'h0, wr_count}, 32'd2);

    // we3 gating.
    we3 = 1'b0; a3 = 5'd8; wd3 = 32'hAAAA5555;
    cycle();
    a1 = 5'd8; a2 = 5'd8;
    #1;
    check("gate_rd1", rd1, 32'h12345678);
    check("gate_same_addr_rd2", rd2, 32'h12345678);
    check("gate_cnt", {16'h0, wr_count}, 32'd2);

    // Same-cycle read of the write address.
    write(5'd9, 32'h1);
    we3 = 1'b1; a3 = 5'd9; a1 = 5'd9; wd3 = 32'h0BADF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp9 = 32'h0BADF00D;
`else
    exp9 = 32'h1;
`endif
    check("same_cycle_pre", rd1, exp9);
    cycle();
    we3 = 1'b0;
    #1;
    check("same_cycle_post", rd1, 32'h0BADF00D);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      we3 = $urandom_range(0, 3) != 0;
      a3 = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 7) == 0) ? a1 : 5'($urandom_range(0, 31));
      #1;
      check("rand_rd1", rd1, exp_rd(a1));
      check("rand_rd2", rd2, exp_rd(a2));
      cycle();
      check("rand_cnt", {16'h0, wr_count}, 32'(m_cnt));
    end
    rst = 1'b1; we3 = 1'b0;

    // Counter wrap after 65537 writes from a clean reset.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    we3 = 1'b1; a3 = 5'd3;
    for (int i = 0; i < 65537; i++) begin
      wd3 = 32'(i) ^ 32'h5A5A0000;
      cycle();
    end
    we3 = 1'b0; a1 = 5'd3;
    #1;
    check("wrap_cnt", {16'h0, wr_count}, 32'd1);
    check("wrap_reg3", rd1, 32'(65536) ^ 32'h5A5A0000);
    check("wrap_model_cnt", {16'h0, wr_count}, 32'(m_cnt));

    // Mid-run reset with a simultaneous write that must be discarded.
    rst = 1'b0; we3 = 1'b1; a3 = 5'd3; wd3 = 32'h77777777;
    cycle();
    rst = 1'b1; we3 = 1'b0;
    #1;
    check("midreset_cnt", {16'h0, wr_count}, 32'h0);
    check("midreset_reg3", rd1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
